// File: rtl/axi_lut_mult_master.sv
// rtl/axi_lut_mult_master.sv - AXI4-Lite read master computing a*b via a product-table ROM lookup.
// Optional per-handshake timeout: AXI_RD_TIMEOUT_EN.
module axi_lut_mult_master #(
    parameter int unsigned              OP_W      = 3,
    parameter int unsigned              ADDR_W    = 32,
    parameter int unsigned              DATA_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0,
    parameter int unsigned              TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*OP_W-1:0]   result,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [2*OP_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   lut_offset;
    logic                unused_rdata;

    // Only the low 2*OP_W bits of a table word carry the product.
    assign unused_rdata = &{1'b0, m_axi_rdata};
    assign lut_offset   = ADDR_W'({a, b}) << 2;

`ifdef AXI_RD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        result_d      = result_q;
        err_d         = err_q;
        req_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        res_valid     = 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    araddr_d = BASE_ADDR + lut_offset;
                    state_d  = S_AR;
`ifdef AXI_RD_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = S_R;
`ifdef AXI_RD_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_hit) begin
                    // Abort: arvalid drops without a handshake; slave needs a reset.
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
`endif
                end
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    if (m_axi_rresp == 2'b00) begin
                        result_d = m_axi_rdata[2*OP_W-1:0];
                        err_d    = 1'b0;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                    state_d = S_RESP;
`ifdef AXI_RD_TIMEOUT_EN
                end else if (tmo_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
`endif
                end
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            araddr_q <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef AXI_RD_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign m_axi_araddr = araddr_q;
    assign result       = result_q;
    assign err          = err_q;

endmodule

// File: tb/tb_axi_lut_mult_master.sv
// tb/tb_axi_lut_mult_master.sv - randomized self-checking bench with a behavioural table-lookup model.
module tb_axi_lut_mult_master;
    localparam int          OP_W = 3;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, res_valid, res_ready, err;
    logic [OP_W-1:0]   a, b;
    logic [2*OP_W-1:0] result;
    logic [31:0]       m_axi_araddr, m_axi_rdata;
    logic              m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [1:0]        m_axi_rresp;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs read by the slave when a transaction starts.
    int cfg_stall = 0, cfg_rdly = 0, cfg_err = 0;

    // Values published by the compare process for directed checks.
    int last_araddr, last_result, last_err, last_lat, last_gap, last_tmo_lat;

    always #5 clk = ~clk;

    axi_lut_mult_master #(
        .OP_W(OP_W), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .a(a), .b(b),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .err(err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Memory-mapped table slave: table word i holds (i >> OP_W) * (i & mask), junk above.
    initial begin : slave
        bit rs, r_pend, ar_seen;
        int stall, r_cnt, r_err, idx;
        logic [31:0] r_addr;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        r_pend = 0; ar_seen = 0; stall = 0; r_cnt = 0; r_err = 0; r_addr = '0;
        forever begin
            @(posedge clk);
            rs = rst;
            #1;
            if (rs) begin
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; r_pend = 0; ar_seen = 0;
            end else begin
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        idx = int'((r_addr - BASE) >> 2);
                        m_axi_rvalid = 1'b1;
                        m_axi_rresp  = (r_err != 0) ? 2'b10 : 2'b00;
                        m_axi_rdata  = ($urandom << (2*OP_W)) |
                                       32'((idx >> OP_W) * (idx & ((1 << OP_W) - 1)));
                        if (m_axi_rready) r_pend = 0;
                    end else begin
                        r_cnt--;
                        m_axi_rvalid = 1'b0;
                    end
                end else begin
                    m_axi_rvalid = ($urandom_range(3) == 0);
                    m_axi_rresp  = 2'b10;
                    m_axi_rdata  = $urandom;
                end
                if (m_axi_arvalid) begin
                    if (!ar_seen) begin ar_seen = 1; stall = cfg_stall; end
                    if (stall == 0) begin
                        m_axi_arready = 1'b1;
                        r_pend = 1; r_cnt = cfg_rdly + 1; r_err = cfg_err;
                        r_addr = m_axi_araddr; ar_seen = 0;
                    end else begin
                        m_axi_arready = 1'b0;
                        stall--;
                    end
                end else begin
                    m_axi_arready = 1'b0;
                end
            end
        end
    end

    // Behavioural model: one transaction tracked by its handshake milestones.
    initial begin : compare
        bit started, busy, ar_done, r_done, res_prev;
        int cyc, acc_cyc, reshs_cyc, mod_a, mod_b, exp_res, exp_err, tmo_cnt;
        logic [31:0] exp_addr;
        started = 0; busy = 0; ar_done = 0; r_done = 0; res_prev = 0;
        cyc = 0; acc_cyc = 0; reshs_cyc = -100; mod_a = 0; mod_b = 0;
        exp_res = 0; exp_err = 0; tmo_cnt = 0; exp_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (started) begin
                chk("req_ready", req_ready, !busy);
                chk("arvalid", m_axi_arvalid, busy && !ar_done);
                chk("rready", m_axi_rready, ar_done && !r_done);
                chk("res_valid", res_valid, r_done);
                if (busy && !ar_done) chk("araddr", m_axi_araddr, exp_addr);
                if (r_done) begin
                    chk("result", result, exp_res);
                    chk("err", err, exp_err);
                end
            end
            if (rst) begin
                started = 1; busy = 0; ar_done = 0; r_done = 0; res_prev = 0;
            end else if (started) begin
                if (res_valid && !res_prev) begin
                    last_lat     = cyc - acc_cyc;
                    last_tmo_lat = cyc - (acc_cyc + 1);
                end
                res_prev = res_valid;
                if (!busy) begin
                    if (req_valid) begin
                        busy = 1; ar_done = 0; r_done = 0; tmo_cnt = 0;
                        mod_a = int'(a); mod_b = int'(b);
                        exp_addr = BASE + 32'(((mod_a << OP_W) + mod_b) * 4);
                        last_gap = cyc - reshs_cyc;
                        acc_cyc  = cyc;
                    end
                end else if (!ar_done) begin
                    if (m_axi_arready) begin
                        ar_done = 1; tmo_cnt = 0; last_araddr = int'(exp_addr);
                    end else begin
                        tmo_cnt++;
`ifdef AXI_RD_TIMEOUT_EN
                        if (tmo_cnt == TMO) begin
                            ar_done = 1; r_done = 1; exp_res = 0; exp_err = 1;
                        end
`endif
                    end
                end else if (!r_done) begin
                    if (m_axi_rvalid) begin
                        r_done  = 1;
                        exp_err = (m_axi_rresp != 2'b00) ? 1 : 0;
                        exp_res = (exp_err != 0) ? 0 : mod_a * mod_b;
                    end else begin
                        tmo_cnt++;
`ifdef AXI_RD_TIMEOUT_EN
                        if (tmo_cnt == TMO) begin
                            r_done = 1; exp_res = 0; exp_err = 1;
                        end
`endif
                    end
                end else if (res_ready) begin
                    busy = 0; ar_done = 0; r_done = 0;
                    last_result = exp_res; last_err = exp_err; reshs_cyc = cyc;
                end
            end
        end
    end

    // Called at posedge+1; returns at negedge+1 of the result handshake cycle.
    task automatic do_req(input int av, input int bv, input int stall, input int rdly,
                          input int e, input int hold);
        int n;
        int h;
        @(posedge clk); #1;
        cfg_stall = stall; cfg_rdly = rdly; cfg_err = e; h = hold;
        res_ready = 1'b0; req_valid = 1'b1; a = OP_W'(av); b = OP_W'(bv);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_wait: req_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; a = OP_W'($urandom); b = OP_W'($urandom);
        n = 0;
        while (n < 300) begin
            if (res_valid) begin
                if (h == 0) begin res_ready = 1'b1; break; end
                h--;
            end
            @(posedge clk); #1; n++;
        end
        if (!res_ready) begin
            checks++; errors++;
            $display("FAIL result_wait: res_valid not seen within %0d cycles", n);
        end
        @(negedge clk); #1;
    endtask

    initial begin : driver
        int n;
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_araddr", m_axi_araddr, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_err", err, 32'h0);
        chk("rst_req_ready", req_ready, 32'h1);
        rst = 1'b0;

        do_req(5, 6, 0, 0, 0, 0);
        chk("d56_araddr", last_araddr, 32'h10B8);
        chk("d56_result", last_result, 30);
        chk("d56_err", last_err, 0);
        chk("d56_latency", last_lat, 4);
        do_req(7, 7, 0, 0, 0, 0);
        chk("d77_araddr", last_araddr, 32'h10FC);
        chk("d77_result", last_result, 49);
        chk("d77_gap", last_gap, 1);
        do_req(0, 7, 0, 0, 0, 0);
        chk("d07_result", last_result, 0);
        do_req(1, 1, 0, 0, 0, 0);
        chk("d11_araddr", last_araddr, 32'h1024);
        chk("d11_result", last_result, 1);
        do_req(3, 5, 5, 3, 0, 0);
        chk("stall_result", last_result, 15);
        do_req(6, 4, 0, 0, 1, 0);
        chk("slverr_err", last_err, 1);
        chk("slverr_result", last_result, 0);
        do_req(2, 3, 0, 0, 0, 0);
        chk("after_err_err", last_err, 0);
        chk("after_err_result", last_result, 6);
        do_req(4, 4, 0, 0, 0, 10);
        chk("hold_result", last_result, 16);
        do_req(2, 5, 0, 0, 0, 0);
        chk("hold_next_gap", last_gap, 1);
        chk("hold_next_result", last_result, 10);

        // Reset while waiting in R.
        @(posedge clk); #1;
        res_ready = 1'b0; cfg_stall = 0; cfg_rdly = 6; cfg_err = 0;
        chk("mid_req_ready", req_ready, 1);
        req_valid = 1'b1; a = 3'd3; b = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!m_axi_rready && n < 20) begin @(posedge clk); #1; n++; end
        chk("mid_in_r", m_axi_rready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_arvalid", m_axi_arvalid, 0);
        chk("mid_rready", m_axi_rready, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_req_ready2", req_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 60; i++) begin
            do_req(int'($urandom_range(7)), int'($urandom_range(7)),
                   int'($urandom_range(4)), int'($urandom_range(4)),
                   ($urandom_range(5) == 0) ? 1 : 0, int'($urandom_range(3)));
        end

`ifdef AXI_RD_TIMEOUT_EN
        do_req(2, 2, 1000, 0, 0, 0);
        chk("tmo_err", last_err, 1);
        chk("tmo_result", last_result, 0);
        chk("tmo_latency", last_tmo_lat, TMO);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(3, 4, 0, 0, 0, 0);
        chk("post_tmo_result", last_result, 12);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
